// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, register control
// codes, ALU op codes, FSM states and the control-word type.
// Optional feature macro used by this slice: CTRL_ILLEGAL_TRAP_EN.
package ctrl_pkg;

  // Instruction opcodes (110 and 111 are illegal)
  localparam logic [2:0] OP_CLRLD = 3'b000;
  localparam logic [2:0] OP_ADDLD = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DISP  = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;

  // Control codes for the X, Y and Z registers
  typedef enum logic [1:0] {
    REG_HOLD   = 2'b00,
    REG_LOAD   = 2'b01,
    REG_SHIFTR = 2'b10,
    REG_RESET  = 2'b11
  } reg_code_e;

  // ALU op codes; widened to ULA_W at the sequencer output
  localparam logic ULA_ADD = 1'b0;
  localparam logic ULA_SUB = 1'b1;

  // One control word as driven to the datapath for one cycle
  typedef struct packed {
    reg_code_e tx;
    reg_code_e ty;
    reg_code_e tz;
    logic      ula;
  } ctrl_word_t;

  // Quiescent word: every register holds, ALU adds
  localparam ctrl_word_t WORD_IDLE = '{tx: REG_HOLD, ty: REG_HOLD, tz: REG_HOLD, ula: ULA_ADD};

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_SHIFT = 2'b10
  } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps an opcode to its control word, flags
// the multi-cycle shift op and flags illegal opcodes (which decode to a NOP).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [2:0]  op,
  output ctrl_word_t  word,
  output logic        is_shift,
  output logic        illegal
);

  // Opcode lookup; unknown opcodes fall through to an all-HOLD NOP
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    word     = WORD_IDLE;
    is_shift = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_CLRLD: word = '{tx: REG_LOAD,  ty: REG_RESET,  tz: REG_RESET, ula: ULA_ADD};
      OP_ADDLD: word = '{tx: REG_LOAD,  ty: REG_LOAD,   tz: REG_HOLD,  ula: ULA_ADD};
      OP_ADD:   word = '{tx: REG_HOLD,  ty: REG_LOAD,   tz: REG_HOLD,  ula: ULA_ADD};
      OP_DIV: begin
        word     = '{tx: REG_HOLD, ty: REG_SHIFTR, tz: REG_HOLD, ula: ULA_ADD};
        is_shift = 1'b1;
      end
      OP_DISP:  word = '{tx: REG_RESET, ty: REG_RESET,  tz: REG_LOAD,  ula: ULA_ADD};
      OP_SUB:   word = '{tx: REG_HOLD,  ty: REG_LOAD,   tz: REG_HOLD,  ula: ULA_SUB};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Control sequencer for the X/Y/Z register + ULA datapath. Accepts one
// instruction at a time over valid/ready and issues registered control words:
// one cycle for simple ops, n cycles of SHIFTR for DIV (amount 0 means 1).
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN -- when defined, an accepted
// illegal opcode sets a sticky err that blocks further accepts until rst.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int SHIFT_W = 3,
  parameter int ULA_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [2:0]         instr_op,
  input  logic [SHIFT_W-1:0] instr_amt,
  output logic               instr_ready,
  output logic [1:0]         tx,
  output logic [1:0]         ty,
  output logic [1:0]         tz,
  output logic [ULA_W-1:0]   tula,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [SHIFT_W-1:0] cnt_q, cnt_d;
  ctrl_word_t         word_q, word_d;
  logic               done_q, done_d;

  ctrl_word_t         dec_word;
  logic               dec_is_shift;
  logic               dec_illegal;
  logic               accept;
  logic [SHIFT_W-1:0] amt_n;

  ctrl_decode u_decode (
    .op       (instr_op),
    .word     (dec_word),
    .is_shift (dec_is_shift),
    .illegal  (dec_illegal)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic err_q, err_d;

  // Ready is a pure decode of registered state; a latched trap blocks accepts
  assign instr_ready = (state_q == ST_IDLE) && !err_q;
  assign err         = err_q;

  // Sticky trap flag, set when an illegal opcode is accepted
  always_comb begin
    err_d = err_q | (accept & dec_illegal);
  end
`else
  // Ready is a pure decode of registered state
  assign instr_ready = (state_q == ST_IDLE);
  assign err         = 1'b0;
`endif

  assign accept = instr_valid && instr_ready;
  // A zero shift amount still shifts once
  assign amt_n  = (instr_amt == '0) ? SHIFT_W'(1) : instr_amt;

  // Next-state, shift counter and next control word
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = WORD_IDLE;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_is_shift) begin
            state_d = ST_SHIFT;
            cnt_d   = amt_n;
            word_d  = dec_word;
            done_d  = (amt_n == SHIFT_W'(1));
          end else begin
            state_d = ST_ISSUE;
            // Illegal opcodes issue as a NOP regardless of the decoded word
            word_d  = dec_illegal ? WORD_IDLE : dec_word;
            done_d  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        // cnt_q counts the shift cycles still to be driven, including this one
        if (cnt_q == SHIFT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q - SHIFT_W'(1);
          word_d = word_q;
          done_d = (cnt_q == SHIFT_W'(2));
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= WORD_IDLE;
      done_q  <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      done_q  <= done_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  assign tx   = word_q.tx;
  assign ty   = word_q.ty;
  assign tz   = word_q.tz;
  assign tula = ULA_W'(word_q.ula);
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer (default parameters).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_ctrl_sequencer;

  localparam int SHIFT_W = 3;
  localparam int ULA_W   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               instr_valid;
  logic [2:0]         instr_op;
  logic [SHIFT_W-1:0] instr_amt;
  logic               instr_ready;
  logic [1:0]         tx, ty, tz;
  logic [ULA_W-1:0]   tula;
  logic               busy, done, err;

  int checks   = 0;
  int failures = 0;

  ctrl_sequencer #(.SHIFT_W(SHIFT_W), .ULA_W(ULA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_op    (instr_op),
    .instr_amt   (instr_amt),
    .instr_ready (instr_ready),
    .tx          (tx),
    .ty          (ty),
    .tz          (tz),
    .tula        (tula),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Packed view: {ready, busy, done, err, tula, tz, ty, tx}
  function automatic logic [11:0] vec(input logic rdy, input logic bsy, input logic dn,
                                      input logic er, input logic [1:0] ula,
                                      input logic [1:0] z, input logic [1:0] y,
                                      input logic [1:0] x);
    return {rdy, bsy, dn, er, ula, z, y, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] expected);
    logic [11:0] observed;
    observed = {instr_ready, busy, done, err, tula, tz, ty, tx};
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%03h expected=%03h", tag, observed, expected);
    end
  endtask

  // Idle: ready, nothing busy, all HOLD, ALU add
  localparam logic [11:0] IDLE_V = 12'h800;

  // Accept a DIV and check n shift cycles followed by a return to idle
  task automatic run_div(input string tag, input logic [SHIFT_W-1:0] amt, input int n);
    instr_valid = 1'b1;
    instr_op    = 3'b011;
    instr_amt   = amt;
    tick();
    instr_valid = 1'b0;
    for (int i = 1; i <= n; i++) begin
      check($sformatf("%s_shift%0d", tag, i),
            vec(1'b0, 1'b1, (i == n), 1'b0, 2'd0, 2'b00, 2'b10, 2'b00));
      tick();
    end
    check({tag, "_end"}, IDLE_V);
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b1;
    instr_op    = 3'b001;
    instr_amt   = '0;

    // Reset held for two edges with a valid ADDLD presented
    tick();
    check("rst_cycle1", IDLE_V);
    tick();
    check("rst_cycle2", IDLE_V);
    instr_valid = 1'b0;
    rst         = 1'b0;
    tick();
    check("rst_release", IDLE_V);

    // ADDLD, then ADD held valid: accepted two cycles after ADDLD
    instr_valid = 1'b1;
    instr_op    = 3'b001;
    tick();
    check("addld_word", vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'b00, 2'b01, 2'b01));
    instr_op = 3'b010;
    tick();
    check("addld_back_idle", IDLE_V);
    tick();
    check("add_word", vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'b00, 2'b01, 2'b00));
    instr_valid = 1'b0;
    tick();
    check("add_back_idle", IDLE_V);

    // DIV shift counts, including amount 0 and the maximum
    run_div("div5", 3'd5, 5);
    run_div("div0", 3'd0, 1);
    run_div("div7", 3'd7, 7);

    // SUB and DISP
    instr_valid = 1'b1;
    instr_op    = 3'b101;
    tick();
    instr_valid = 1'b0;
    check("sub_word", vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'b00, 2'b01, 2'b00));
    tick();
    check("sub_back_idle", IDLE_V);
    instr_valid = 1'b1;
    instr_op    = 3'b100;
    tick();
    instr_valid = 1'b0;
    check("disp_word", vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'b01, 2'b11, 2'b11));
    tick();
    check("disp_back_idle", IDLE_V);

    // Reset on the 3rd of 6 shift cycles aborts without a done pulse
    instr_valid = 1'b1;
    instr_op    = 3'b011;
    instr_amt   = 3'd6;
    tick();
    instr_valid = 1'b0;
    check("abort_shift1", vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 2'b10, 2'b00));
    tick();
    tick();
    check("abort_shift3", vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 2'b10, 2'b00));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_idle", IDLE_V);
    instr_valid = 1'b1;
    instr_op    = 3'b000;
    tick();
    instr_valid = 1'b0;
    check("clrld_word", vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'b11, 2'b11, 2'b01));
    tick();
    check("clrld_back_idle", IDLE_V);

    // Illegal opcode 111
    instr_valid = 1'b1;
    instr_op    = 3'b111;
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("illegal_nop", vec(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'b00, 2'b00, 2'b00));
    instr_op = 3'b010;
    tick();
    check("trap_blocked1", vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'b00, 2'b00, 2'b00));
    tick();
    check("trap_blocked2", vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'b00, 2'b00, 2'b00));
    instr_valid = 1'b0;
    rst         = 1'b1;
    tick();
    rst = 1'b0;
    check("trap_cleared", IDLE_V);
`else
    instr_valid = 1'b0;
    check("illegal_nop", vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'b00, 2'b00, 2'b00));
    tick();
    check("illegal_back_idle", IDLE_V);
    instr_valid = 1'b1;
    instr_op    = 3'b010;
    tick();
    instr_valid = 1'b0;
    check("after_illegal_add", vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'b00, 2'b01, 2'b00));
    tick();
    check("after_illegal_idle", IDLE_V);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
